shadow_round_ctrl: RTL and testbench

Sequencing controller for the masked Shadow-512 permutation. Drives the shared masked S-box datapath, which operates on the column representation after bundle-to-column conversion and returns through column-to-bundle conversion. It serially issues the state bundles of each half-step and gates one fresh-randomness transfer per issue. It then triggers the linear layer (L-box or D-box) plus round-constant addition, and reports completion after all steps.

---
 rtl/shadow_round_ctrl_pkg.sv | 12 +
 rtl/shadow_wb_tracker.sv | 30 +++
 rtl/shadow_round_ctrl.sv | 114 +++++++++++
 tb/tb_shadow_round_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/shadow_round_ctrl_pkg.sv
// shadow_ctrl_pkg: FSM states, default sizing and index-width helpers for the Shadow-512 round controller.
package shadow_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_LIN, S_DONE} state_t;
    localparam int D_DEF      = 2;
    localparam int NB_DEF     = 4;
    localparam int NSTEPS_DEF = 6;
    localparam int SB_LAT_DEF = 2;
    localparam int RC_W       = 4;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/shadow_wb_tracker.sv
// shadow_wb_tracker: LAT-deep (valid, idx) delay line turning S-box issues into write-back strobes.
module shadow_wb_tracker #(
    parameter int LAT = 2,
    parameter int BW  = 2
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sb_en_i,
    input  logic [BW-1:0] bundle_idx_i,
    output logic          state_we_o,
    output logic [BW-1:0] wb_idx_o
);
    logic [LAT-1:0]         r_v;
    logic [LAT-1:0][BW-1:0] r_idx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_idx <= '0;
        end else begin
            r_v[0]   <= sb_en_i;
            r_idx[0] <= bundle_idx_i;
            for (int i = 1; i < LAT; i++) begin
                r_v[i]   <= r_v[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end
    assign state_we_o = r_v[LAT-1];
    assign wb_idx_o   = r_idx[LAT-1];
endmodule

// File: rtl/shadow_round_ctrl.sv
// shadow_round_ctrl: sequences bundle issue, S-box drain, linear layer and round constants of masked Shadow-512.
module shadow_round_ctrl
    import shadow_ctrl_pkg::*;
#(
    parameter int d      = D_DEF,
    parameter int NB     = NB_DEF,
    parameter int NSTEPS = NSTEPS_DEF,
    parameter int SB_LAT = SB_LAT_DEF
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  rnd_valid_i,
    output logic                  rnd_ready_o,
    output logic                  sb_en_o,
    output logic [idx_w(NB)-1:0]  bundle_idx_o,
    output logic                  state_we_o,
    output logic [idx_w(NB)-1:0]  wb_idx_o,
    output logic                  lbox_en_o,
    output logic                  dbox_en_o,
    output logic                  rc_add_en_o,
    output logic [RC_W-1:0]       rc_idx_o
);
    localparam int BW  = idx_w(NB);
    localparam int SW  = idx_w(NSTEPS);
    // Share count does not shape control; it only sanitises the latency used for sizing.
    localparam int LAT = (d > 0 && SB_LAT > 0) ? SB_LAT : 1;
    localparam int DW  = idx_w(LAT);

    state_t        r_state, w_state_n;
    logic [SW-1:0] r_step, w_step_n;
    logic          r_half, w_half_n;
    logic [BW-1:0] r_bidx, w_bidx_n;
    logic [DW-1:0] r_drain, w_drain_n;
    logic          w_sb_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_half  <= 1'b0;
            r_bidx  <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_n;
            r_step  <= w_step_n;
            r_half  <= w_half_n;
            r_bidx  <= w_bidx_n;
            r_drain <= w_drain_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_step_n  = r_step;
        w_half_n  = r_half;
        w_bidx_n  = r_bidx;
        w_drain_n = r_drain;
        w_sb_en   = 1'b0;
        case (r_state)
            S_IDLE: if (start_i) begin
                w_step_n  = '0;
                w_half_n  = 1'b0;
                w_bidx_n  = '0;
                w_state_n = S_ISSUE;
            end
            S_ISSUE: if (rnd_valid_i) begin
                w_sb_en = 1'b1;
                if (r_bidx == BW'(NB - 1)) begin
                    w_bidx_n  = '0;
                    w_drain_n = '0;
                    w_state_n = S_DRAIN;
                end else begin
                    w_bidx_n = r_bidx + 1'b1;
                end
            end
            S_DRAIN: begin
                w_drain_n = r_drain + 1'b1;
                w_state_n = (r_drain == DW'(LAT - 1)) ? S_LIN : S_DRAIN;
            end
            S_LIN: begin
                w_half_n  = ~r_half;
                w_state_n = S_ISSUE;
                if (r_half && r_step != SW'(NSTEPS - 1))
                    w_step_n = r_step + 1'b1;
                else if (r_half)
                    w_state_n = S_DONE;
            end
            S_DONE: w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    assign busy_o       = r_state != S_IDLE;
    assign done_o       = r_state == S_DONE;
    assign sb_en_o      = w_sb_en;
    assign rnd_ready_o  = w_sb_en;
    assign bundle_idx_o = r_bidx;
    assign rc_add_en_o  = r_state == S_LIN;
    assign lbox_en_o    = rc_add_en_o && !r_half;
    assign dbox_en_o    = rc_add_en_o && r_half;
    assign rc_idx_o     = (r_state inside {S_ISSUE, S_DRAIN, S_LIN}) ? RC_W'({r_step, r_half}) : '0;

    shadow_wb_tracker #(.LAT(LAT), .BW(BW)) u_wb (
        .clk          (clk),
        .rst_n        (rst_n),
        .sb_en_i      (w_sb_en),
        .bundle_idx_i (r_bidx),
        .state_we_o   (state_we_o),
        .wb_idx_o     (wb_idx_o)
    );
endmodule

// File: tb/tb_shadow_round_ctrl.sv
// tb_shadow_round_ctrl: scoreboard bench for issue, write-back, linear-layer and done timing.
module tb_shadow_round_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, a_start = 1'b0, b_start = 1'b0, rnd_valid = 1'b1;
    always #5 clk = ~clk;

    logic       a_busy, a_done, a_ready, a_sb_en, a_we, a_l, a_d, a_rca;
    logic [1:0] a_bidx, a_wbidx;
    logic [3:0] a_rc;
    logic       b_busy, b_done, b_ready, b_sb_en, b_we, b_l, b_d, b_rca;
    logic [1:0] b_bidx, b_wbidx;
    logic [3:0] b_rc;
    logic       m_busy, m_done, m_ready, m_sb_en, m_we, m_l, m_d, m_rca;
    logic [1:0] m_bidx, m_wbidx;
    logic [3:0] m_rc;
    logic [15:0] a_bus, b_bus, m_bus;
    bit sel = 1'b0, active = 1'b0;

    shadow_round_ctrl #(.d(2), .NB(4), .NSTEPS(6), .SB_LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
        .rnd_valid_i(rnd_valid), .rnd_ready_o(a_ready), .sb_en_o(a_sb_en), .bundle_idx_o(a_bidx),
        .state_we_o(a_we), .wb_idx_o(a_wbidx), .lbox_en_o(a_l), .dbox_en_o(a_d),
        .rc_add_en_o(a_rca), .rc_idx_o(a_rc)
    );
    shadow_round_ctrl #(.d(2), .NB(4), .NSTEPS(6), .SB_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
        .rnd_valid_i(rnd_valid), .rnd_ready_o(b_ready), .sb_en_o(b_sb_en), .bundle_idx_o(b_bidx),
        .state_we_o(b_we), .wb_idx_o(b_wbidx), .lbox_en_o(b_l), .dbox_en_o(b_d),
        .rc_add_en_o(b_rca), .rc_idx_o(b_rc)
    );

    assign a_bus = {a_busy, a_done, a_sb_en, a_ready, a_we, a_l, a_d, a_rca, a_bidx, a_wbidx, a_rc};
    assign b_bus = {b_busy, b_done, b_sb_en, b_ready, b_we, b_l, b_d, b_rca, b_bidx, b_wbidx, b_rc};
    assign m_bus = sel ? b_bus : a_bus;
    assign {m_busy, m_done, m_sb_en, m_ready, m_we, m_l, m_d, m_rca, m_bidx, m_wbidx, m_rc} = m_bus;

    int cyc = 0, base = 0, checks = 0, failures = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int c; int v;} ev_t;
    ev_t q_iss[$], q_wb[$], q_lin[$];
    int  q_done[$];

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", n, act, exp, $time);
        end
    endtask

    // Expected events are cycle-stamped relative to the start period.
    int mr;
    ev_t me;
    always @(negedge clk) if (active) begin
        mr = cyc - base;
        if (m_sb_en) begin
            if (q_iss.size() == 0) check("issue_unexpected", mr, -1);
            else begin
                me = q_iss.pop_front();
                check("issue_cyc_idx", mr * 10 + m_bidx, me.c * 10 + me.v);
                check("issue_rnd_ready", m_ready, 1);
            end
        end
        if (m_we) begin
            check("wb_not_in_lin", m_l | m_d, 0);
            if (q_wb.size() == 0) check("wb_unexpected", mr, -1);
            else begin
                me = q_wb.pop_front();
                check("wb_cyc_idx", mr * 10 + m_wbidx, me.c * 10 + me.v);
            end
        end
        if (m_l | m_d) begin
            if (q_lin.size() == 0) check("lin_unexpected", mr, -1);
            else begin
                me = q_lin.pop_front();
                check("lin_cyc_rc_sel", mr * 100 + int'({m_rc, m_l, m_d, m_rca}), me.c * 100 + me.v);
            end
        end
        if (m_done) begin
            if (q_done.size() == 0) check("done_unexpected", mr, -1);
            else check("done_cyc", mr, q_done.pop_front());
        end
    end

    task automatic gen(input int lat, input bit stall, input int cut, input int done_c);
        int p, c;
        p = 4 + lat + 1;
        for (int h = 0; h < 12; h++) begin
            for (int b = 0; b < 4; b++) begin
                c = h * p + 1 + b + ((stall && (h > 5 || (h == 5 && b >= 2))) ? 3 : 0);
                if (c < cut) q_iss.push_back(ev_t'{c, b});
                if (c + lat < cut) q_wb.push_back(ev_t'{c + lat, b});
            end
            c = h * p + p + ((stall && h >= 5) ? 3 : 0);
            if (c < cut) q_lin.push_back(ev_t'{c, h * 8 + ((h % 2 == 0) ? 5 : 3)});
        end
        if (done_c < cut) q_done.push_back(done_c);
    endtask

    task automatic run(input bit s, input int lat, input int exp_done, input bit stall,
                       input bit pulses, input int rst_at);
        int  last;
        bit  st;
        sel = s;
        gen(lat, stall, (rst_at >= 0) ? rst_at : 1 << 20, exp_done);
        last   = (rst_at >= 0) ? rst_at + 4 : exp_done;
        base   = cyc;
        active = 1'b1;
        for (int r = 0; r <= last; r++) begin
            st        = (r == 0) || (pulses && (r == 10 || r == 85));
            a_start   = st && !s;
            b_start   = st && s;
            rnd_valid = !(stall && r >= 38 && r <= 40);
            if (rst_at >= 0 && r == rst_at) #1 rst_n = 1'b0;
            if (rst_at >= 0 && r == rst_at + 3) rst_n = 1'b1;
            @(negedge clk);
            if (r == 0) begin
                check("idle_busy", m_busy, 0);
                check("idle_rc_idx", m_rc, 0);
            end
            if (r == 1) check("busy_after_start", m_busy, 1);
            if (rst_at < 0 && r == exp_done) check("busy_at_done", m_busy, 1);
            if (stall && r >= 38 && r <= 40) begin
                check("stall_bundle_idx", m_bidx, 2);
                check("stall_rnd_ready", m_ready, 0);
            end
            if (rst_at >= 0 && r >= rst_at && r < rst_at + 3) check("reset_outputs_zero", m_bus, 0);
            @(posedge clk);
            #1;
        end
        a_start   = 1'b0;
        b_start   = 1'b0;
        rnd_valid = 1'b1;
        check("issues_all_seen", q_iss.size(), 0);
        check("wbs_all_seen", q_wb.size(), 0);
        check("lins_all_seen", q_lin.size(), 0);
        check("done_seen", q_done.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a_outputs", a_bus, 0);
        check("reset_b_outputs", b_bus, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run(1'b0, 2, 85, 1'b0, 1'b1, -1);
        run(1'b0, 2, 88, 1'b1, 1'b0, -1);
        run(1'b0, 2, 85, 1'b0, 1'b0, 40);
        run(1'b0, 2, 85, 1'b0, 1'b0, -1);
        run(1'b1, 3, 97, 1'b0, 1'b0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
